display_writer: RTL and testbench
=================================

DISPLAY_WRITER -- requirements
Module: display_writer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock for the block; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to convert and write one value; sampled on the rising edge.
REQ-005 value  input  16  unsigned binary value to display.
REQ-006 dp_en  input  1  enables the decimal point.
REQ-007 dp_pos  input  3  digit index (0 = rightmost) that carries the decimal point.
REQ-008 blank_lz  input  1  enables leading-zero blanking.
REQ-009 W  output  1  write strobe to the display RAM; one entry is written per clk cycle while high.
REQ-010 WADD  output  3  display RAM write address, which is also the digit index.
REQ-011 DIN  output  6  display RAM write data: DIN[5] = digit enable, DIN[4:1] = BCD digit, DIN[0] = decimal point.
REQ-012 busy  output  1  high while a conversion or write burst is in progress.
REQ-013 done  output  1  one-cycle pulse after the last write of a burst.

Function
REQ-014 The FSM SHALL have four states: IDLE, CONV, WRITE and DONE.
REQ-015 Start acceptance:
- start SHALL be accepted only in IDLE; start in CONV, WRITE or DONE SHALL be ignored.
- On acceptance, value, dp_en, dp_pos and blank_lz SHALL be captured internally.
- Input changes after acceptance SHALL NOT affect the burst in progress.
REQ-016 CONV SHALL perform a shift-and-add-3 binary-to-BCD conversion, one input bit per cycle, MSB first, for exactly 16 cycles, producing 5 BCD digits d4..d0 (d0 least significant).
REQ-017 WRITE SHALL last exactly 8 cycles:
- W = 1 throughout.
- WADD SHALL step 0,1,...,7, one address per cycle.
- DIN SHALL be valid in the same cycle as the WADD it belongs to.
REQ-018 Digit content:
- Digit k <= 4 SHALL carry BCD = dk.
- Digits 5, 6 and 7 SHALL always be written as DIN = 0 (blank, no decimal point).
REQ-019 Leading-zero blanking: with captured blank_lz = 1, digit k (1 <= k <= 4) SHALL have enable = 0 and BCD = 0 when all of the following hold:
- dk..d4 are all zero;
- k > dp_pos, or dp_en = 0.
REQ-020 Enable rules:
- With blank_lz = 0, digits 0..4 SHALL always have enable = 1.
- Digit 0 SHALL never be blanked.
REQ-021 DIN[0] SHALL be 1 only at WADD == captured dp_pos when captured dp_en = 1, including dp_pos 5..7 (enable and BCD still 0 there).
REQ-022 DONE SHALL last exactly 1 cycle with done = 1 and busy = 0, then return to IDLE.
REQ-023 busy SHALL be 1 in CONV and WRITE and 0 in IDLE and DONE.
REQ-024 W SHALL be 0 in every state other than WRITE.
REQ-025 Outside WRITE, WADD and DIN SHALL be 0.
REQ-026 Cycle timing, with start accepted at edge E0:
- busy rises after E0.
- The first write occurs in the cycle after E16 (WADD 0).
- The last write occurs in the cycle after E23 (WADD 7).
- done = 1 in the cycle after E24.
- IDLE is re-entered after E25, and a new start is accepted from E25 on.
REQ-027 The burst length SHALL be independent of value; the WADD wrap from 7 SHALL end the burst, with no ninth write.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately (asynchronously) force the following, regardless of state, including in the middle of CONV or WRITE:
- state = IDLE;
- W = 0, WADD = 0, DIN = 0;
- busy = 0, done = 0;
- internal shift, digit and counter registers = 0.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high in IDLE.
REQ-030 A burst interrupted by reset SHALL NOT resume, and SHALL NOT produce done.

Verification
REQ-031 value = 12345, dp_en = 0, blank_lz = 1 -> writes WADD0..7 = 0x2A, 0x28, 0x26, 0x24, 0x22, 0x00, 0x00, 0x00; done 25 cycles after start.
REQ-032 value = 0, dp_en = 0, blank_lz = 1 -> WADD0 = 0x20, WADD1..7 = 0x00; with blank_lz = 0 -> WADD0..4 = 0x20, WADD5..7 = 0x00.
REQ-033 value = 7, dp_en = 1, dp_pos = 2, blank_lz = 1 -> WADD0 = 0x2E, WADD1 = 0x20, WADD2 = 0x21, WADD3..7 = 0x00.
REQ-034 value = 65535, blank_lz = 1 -> WADD0..4 = 0x2A, 0x26, 0x2A, 0x2A, 0x2C; exactly 8 W cycles.
REQ-035 start pulsed again at E5 and E20 with a different value -> ignored; the written data reflects the first value only; a single done pulse.
REQ-036 rst_n low for one cycle during WRITE (at WADD 3) -> W, busy and DIN drop to 0 asynchronously; no further writes and no done; the next start produces a complete correct burst.

Source files
------------

// File: rtl/display_writer.sv
// Converts a 16-bit binary value to five BCD digits and writes an 8-entry
// burst (digits, decimal point, leading-zero blanking) into a display RAM.
module display_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        dp_en,
  input  logic [2:0]  dp_pos,
  input  logic        blank_lz,
  output logic        W,
  output logic [2:0]  WADD,
  output logic [5:0]  DIN,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_shift;
  logic [19:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [2:0]  r_addr;
  logic        r_dp_en;
  logic [2:0]  r_dp_pos;
  logic        r_blank_lz;

  logic [18:0] w_bcd_adj;
  logic [5:0]  w_din_tab [8];
  logic        w_zero_run;
  logic        w_blank;
  logic [3:0]  w_digit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal driven here gets a default before the case, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)            w_next = S_CONV;
      S_CONV:  if (r_cnt == 4'd15)   w_next = S_WRITE;
      S_WRITE: if (r_addr == 3'd7)   w_next = S_DONE;
      S_DONE:                        w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double-dabble adjust. d4 never exceeds 3 before the final shift (65535
  // tops out at 6), so only d0..d3 need the add-3 correction.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bcd_adj[18:16] = r_bcd[18:16];
    for (int i = 0; i < 4; i++) begin
      w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                       : r_bcd[4*i +: 4];
    end
  end

  // NOTE: the datapath registers are reset explicitly as well, so a burst cut
  // short by reset leaves no stale digits or counters behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_dp_en    <= 1'b0;
      r_dp_pos   <= '0;
      r_blank_lz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift    <= value;
            r_dp_en    <= dp_en;
            r_dp_pos   <= dp_pos;
            r_blank_lz <= blank_lz;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
          end
        end
        S_CONV: begin
          r_bcd   <= {w_bcd_adj, r_shift[15]};
          r_shift <= {r_shift[14:0], 1'b0};
          r_cnt   <= r_cnt + 4'd1;
        end
        S_WRITE: begin
          r_addr <= r_addr + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-address write data. Walk from d4 downwards keeping a running
  // "everything above is zero" flag to find the leading zeros.
  // ---------------------------------------------------------------------------
  // NOTE: blocking assignments are used inside always_comb so the running flag
  // updates in loop order; sequential blocks above use non-blocking only.
  always_comb begin
    w_zero_run = 1'b1;
    w_blank    = 1'b0;
    w_digit    = '0;
    for (int k = 0; k < 8; k++) begin
      w_din_tab[k] = {5'b0, r_dp_en && (r_dp_pos == 3'(k))};
    end
    for (int k = 4; k >= 0; k--) begin
      w_digit    = r_bcd[4*k +: 4];
      w_zero_run = w_zero_run && (w_digit == 4'd0);
      w_blank    = r_blank_lz && (k != 0) && w_zero_run &&
                   (!r_dp_en || (3'(k) > r_dp_pos));
      if (!w_blank) begin
        w_din_tab[k][5:1] = {1'b1, w_digit};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decode from state only, so reset clears them without waiting for
  // a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    W    = 1'b0;
    WADD = '0;
    DIN  = '0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_CONV: busy = 1'b1;
      S_WRITE: begin
        busy = 1'b1;
        W    = 1'b1;
        WADD = r_addr;
        DIN  = w_din_tab[r_addr];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_writer.sv
// Self-checking bench for display_writer: table vectors, hand sequences for
// ignored starts, chained bursts and mid-burst reset, then randomized bursts.
module tb_display_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] value;
  logic        dp_en;
  logic [2:0]  dp_pos;
  logic        blank_lz;
  logic        W;
  logic [2:0]  WADD;
  logic [5:0]  DIN;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0]     value;
    logic            dp_en;
    logic [2:0]      dp_pos;
    logic            blank_lz;
    logic            glitch;
    logic [7:0][5:0] exp;
  } vec_t;

  vec_t tbl [8];

  display_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .dp_en    (dp_en),
    .dp_pos   (dp_pos),
    .blank_lz (blank_lz),
    .W        (W),
    .WADD     (WADD),
    .DIN      (DIN),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] v, input logic de, input logic [2:0] dp,
                              input logic bl, input logic gl,
                              input logic [5:0] a0, input logic [5:0] a1,
                              input logic [5:0] a2, input logic [5:0] a3,
                              input logic [5:0] a4, input logic [5:0] a5,
                              input logic [5:0] a6, input logic [5:0] a7);
    vec_t r;
    r.value    = v;
    r.dp_en    = de;
    r.dp_pos   = dp;
    r.blank_lz = bl;
    r.glitch   = gl;
    r.exp[0] = a0; r.exp[1] = a1; r.exp[2] = a2; r.exp[3] = a3;
    r.exp[4] = a4; r.exp[5] = a5; r.exp[6] = a6; r.exp[7] = a7;
    return r;
  endfunction

  // Reference: digits by decimal arithmetic, blanking straight from the rules.
  function automatic logic [5:0] model_din(input int v, input bit de, input int dp,
                                           input bit bl, input int k);
    int  d [5];
    int  div;
    bit  higher_zero;
    bit  dp_bit;
    bit  blank;
    div = 1;
    for (int i = 0; i < 5; i++) begin
      d[i] = (v / div) % 10;
      div  = div * 10;
    end
    dp_bit = de && (dp == k);
    if (k > 4) return {5'b0, dp_bit};
    higher_zero = 1'b1;
    for (int i = k; i < 5; i++) if (d[i] != 0) higher_zero = 1'b0;
    blank = bl && (k >= 1) && higher_zero && ((k > dp) || !de);
    if (blank) return {5'b0, dp_bit};
    return {1'b1, 4'(d[k]), dp_bit};
  endfunction

  // Expected {busy, done, W, WADD, DIN} in the cycle after edge E(idx).
  function automatic logic [11:0] exp_cycle(input int idx, input logic [7:0][5:0] e);
    if (idx < 16) return 12'h800;
    if (idx < 24) return {3'b101, 3'(idx - 16), e[idx - 16]};
    if (idx == 24) return 12'h400;
    return 12'h000;
  endfunction

  task automatic start_burst(input logic [15:0] v, input logic de, input logic [2:0] dp,
                             input logic bl);
    value    = v;
    dp_en    = de;
    dp_pos   = dp;
    blank_lz = bl;
    start    = 1'b1;
  endtask

  // Called at the falling edge right after the accepting edge E0.
  task automatic check_burst(input string name, input logic [7:0][5:0] e, input bit glitch,
                             input bit chain, input vec_t nxt);
    for (int idx = 0; idx < 26; idx++) begin
      check($sformatf("%s_c%0d", name, idx), {20'b0, busy, done, W, WADD, DIN},
            {20'b0, exp_cycle(idx, e)});
      if (idx == 0) begin
        start    = 1'b0;
        value    = 16'($urandom);
        dp_en    = 1'($urandom);
        dp_pos   = 3'($urandom);
        blank_lz = 1'($urandom);
      end
      if (glitch && (idx == 4 || idx == 19)) begin
        start = 1'b1;
        value = 16'($urandom);
      end
      if (glitch && (idx == 5 || idx == 20)) start = 1'b0;
      if (chain && idx == 25) start_burst(nxt.value, nxt.dp_en, nxt.dp_pos, nxt.blank_lz);
      @(negedge clk);
    end
  endtask

  task automatic run_burst(input string name, input vec_t t);
    start_burst(t.value, t.dp_en, t.dp_pos, t.blank_lz);
    @(negedge clk);
    check_burst(name, t.exp, t.glitch, 1'b0, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    int   w_seen;
    int   done_seen;

    tbl[0] = mk(16'd12345, 0, 3'd0, 1, 0, 6'h2A, 6'h28, 6'h26, 6'h24, 6'h22, 6'h00, 6'h00, 6'h00);
    tbl[1] = mk(16'd0,     0, 3'd0, 1, 0, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    tbl[2] = mk(16'd0,     0, 3'd0, 0, 0, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h00, 6'h00, 6'h00);
    tbl[3] = mk(16'd7,     1, 3'd2, 1, 0, 6'h2E, 6'h20, 6'h21, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    tbl[4] = mk(16'd65535, 0, 3'd0, 1, 0, 6'h2A, 6'h26, 6'h2A, 6'h2A, 6'h2C, 6'h00, 6'h00, 6'h00);
    tbl[5] = mk(16'd5,     1, 3'd6, 1, 0, 6'h2A, 6'h20, 6'h20, 6'h20, 6'h20, 6'h00, 6'h01, 6'h00);
    tbl[6] = mk(16'd100,   1, 3'd0, 1, 0, 6'h21, 6'h20, 6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    tbl[7] = mk(16'd12345, 1, 3'd7, 0, 1, 6'h2A, 6'h28, 6'h26, 6'h24, 6'h22, 6'h00, 6'h00, 6'h01);

    rst_n    = 1'b0;
    start    = 1'b0;
    value    = '0;
    dp_en    = 1'b0;
    dp_pos   = '0;
    blank_lz = 1'b0;
    #1;
    check("reset_outputs", {20'b0, busy, done, W, WADD, DIN}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; the first start right after reset release must be taken.
    for (int i = 0; i < 8; i++) run_burst($sformatf("tbl%0d", i), tbl[i]);

    // Second start issued as soon as IDLE is back after the first burst.
    start_burst(tbl[3].value, tbl[3].dp_en, tbl[3].dp_pos, tbl[3].blank_lz);
    @(negedge clk);
    check_burst("chainA", tbl[3].exp, 1'b0, 1'b1, tbl[4]);
    check_burst("chainB", tbl[4].exp, 1'b0, 1'b0, tbl[4]);

    // Reset pulse in the middle of WRITE, at WADD 3.
    start_burst(tbl[0].value, tbl[0].dp_en, tbl[0].dp_pos, tbl[0].blank_lz);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("rst_pre", {20'b0, busy, done, W, WADD, DIN}, {20'b0, exp_cycle(19, tbl[0].exp)});
    rst_n = 1'b0;
    #1;
    check("rst_async", {20'b0, busy, done, W, WADD, DIN}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    w_seen    = 0;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      w_seen    += int'(W);
      done_seen += int'(done);
    end
    check("rst_no_write", w_seen, 0);
    check("rst_no_done", done_seen, 0);
    run_burst("post_rst", tbl[6]);

    // Randomized bursts against the arithmetic reference model.
    for (int n = 0; n < 12; n++) begin
      r.value    = 16'($urandom);
      if (n % 3 == 0) r.value = 16'($urandom_range(0, 120));
      r.dp_en    = 1'($urandom);
      r.dp_pos   = 3'($urandom);
      r.blank_lz = 1'($urandom);
      r.glitch   = 1'($urandom);
      for (int k = 0; k < 8; k++)
        r.exp[k] = model_din(int'(r.value), r.dp_en, int'(r.dp_pos), r.blank_lz, k);
      run_burst($sformatf("rnd%0d", n), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
